binary_to_bcd_encoder: RTL and testbench
========================================

// Module: binary_to_bcd_encoder
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Takes an unsigned binary count and produces a packed 6-digit BCD word.
//   Output bcd_value is laid out for direct connection to the value[24:0]
//   input of BCD_decoder, which drives the six seven-segment digits.
//   Sits between datapath counters/accumulators and the display decoder.
// PARAMETERS
//   BIN_W   20  width of binary_in; default covers 0..999999 plus overflow range
//   DIGITS  6   number of BCD digits produced; bcd_value width = 4*DIGITS+1
// PORTS
//   clk        in   1          system clock; all state changes on rising edge
//   rst_n      in   1          synchronous reset, active low
//   binary_in  in   BIN_W      unsigned value to convert; sampled on accepted start
//   start      in   1          request conversion; accepted only in IDLE
//   busy       out  1          high while in SHIFT or DONE; start is ignored
//   done       out  1          one-cycle pulse; bcd_value/overflow are new from this cycle
//   bcd_value  out  4*DIGITS+1 digit k at [4k+3:4k]; MSB (bit 24) always 0
//   overflow   out  1          last conversion input exceeded 10^DIGITS-1
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, bcd_value=0,
//     overflow=0, shift/scratch/counter registers cleared. Reset aborts any
//     conversion in progress; the partial result is discarded.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: if start=1 at an edge, load shift_reg=binary_in, scratch BCD=0,
//     iter=0, ovf_cap=(binary_in > 10^DIGITS-1); go to SHIFT.
//   SHIFT: at each edge, every scratch digit >=5 gets +3 (4-bit, no carry
//     out), then {scratch,shift_reg} shifts left by 1; iter++. On the edge
//     completing iteration BIN_W: bcd_value <= ovf_cap ? all digits 9 : scratch,
//     overflow <= ovf_cap; go to DONE.
//   DONE: done=1 for exactly this cycle; next edge -> IDLE.
//   Latency: start high in cycle N -> done high in cycle N+BIN_W+1 (21 by default).
//   Throughput: next start can be accepted in cycle N+BIN_W+2.
//   bcd_value and overflow hold their value between DONE loads.
//   They never show intermediate scratch, so displays do not flicker.
//   start while busy: ignored; no queueing. start held high: restarts in IDLE each time.
//   binary_in changes during SHIFT: no effect; the value captured at start is used.
//   Overflow saturates to 999999 (0x0999999); no wrap-around.
//   Counter iter width = clog2(BIN_W+1); must not wrap before BIN_W.
// CONFIGURATION
//   BCD_ENC_AUTO_EN defined: IDLE also starts a conversion when
//     binary_in != last_converted, which is a register updated on each
//     accepted start and reset to 0. Displays then track a live count with
//     no external start. External start still works and is ORed in.
//   BCD_ENC_AUTO_EN undefined: conversions start only on start; no
//     last_converted register is built.
// TESTING
//   Reset, then idle 5 cycles -> bcd_value=0, busy=0, done=0, overflow=0.
//   binary_in=123456, start in cycle N -> busy from N+1, done only in N+21,
//     bcd_value=0x0123456, overflow=0.
//   binary_in=999999 -> bcd_value=0x0999999, overflow=0.
//   binary_in=1000000 and binary_in=1048575 -> bcd_value=0x0999999, overflow=1.
//   start for 42 in cycle N, then start with binary_in=7 in cycles N+5..N+20
//     -> result 0x0000042, single done pulse.
//   Convert 500, start 900, rst_n=0 in cycle N+10 -> next cycle all outputs 0
//     and no done; then 9 -> 0x0000009.
//   [BCD_ENC_AUTO_EN] binary_in 0->37, no start -> done 21 cycles later,
//     0x0000037; constant input -> no further done.

Source files
------------

// File: rtl/binary_to_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD converter, saturating on overflow.
// Optional BCD_ENC_AUTO_EN: also start whenever binary_in differs from the last value converted.
module binary_to_bcd_encoder #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    binary_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS:0]   bcd_value,
    output logic                overflow
);

    localparam int SCR_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(BIN_W + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

    function automatic logic [63:0] max_val();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < DIGITS; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    function automatic logic [SCR_W-1:0] all_nines();
        logic [SCR_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'h9;
        return r;
    endfunction

    localparam logic [63:0]      MAX_VAL = max_val();
    localparam logic [SCR_W-1:0] NINES   = all_nines();

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [BIN_W-1:0]  shift_reg;
    logic [SCR_W-1:0]  scratch;
    logic [ITER_W-1:0] iter;
    logic              ovf_cap;

    logic [SCR_W-1:0]  adjusted;
    logic [SCR_W-1:0]  next_scratch;
    logic [BIN_W-1:0]  next_shift;
    logic              trigger;
    logic              in_range_ovf;

    assign in_range_ovf = 64'(binary_in) > MAX_VAL;

`ifdef BCD_ENC_AUTO_EN
    logic [BIN_W-1:0] last_converted;

    assign trigger = start || (binary_in != last_converted);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_converted <= '0;
        end else if (state == IDLE && trigger) begin
            last_converted <= binary_in;
        end
    end
`else
    assign trigger = start;
`endif

    // Add-3 correction on each digit before the shift; carries out of a digit cannot occur.
    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    assign next_scratch = {adjusted[SCR_W-2:0], shift_reg[BIN_W-1]};
    assign next_shift   = {shift_reg[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_value <= '0;
            overflow  <= 1'b0;
            shift_reg <= '0;
            scratch   <= '0;
            iter      <= '0;
            ovf_cap   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        shift_reg <= binary_in;
                        scratch   <= '0;
                        iter      <= '0;
                        ovf_cap   <= in_range_ovf;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= next_shift;
                    scratch   <= next_scratch;
                    iter      <= iter + ITER_W'(1);
                    // Results are only exposed once complete so displays never flicker.
                    if (iter == LAST_ITER) begin
                        bcd_value <= {1'b0, ovf_cap ? NINES : next_scratch};
                        overflow  <= ovf_cap;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_encoder.sv
// Scoreboard bench for binary_to_bcd_encoder: random and directed
// conversions checked against a decimal-arithmetic reference model.
module tb_binary_to_bcd_encoder;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = BIN_W + 1;

    typedef struct {
        logic [24:0] val;
        logic        ovf;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [BIN_W-1:0]  binary_in;
    logic              start;
    logic              busy;
    logic              done;
    logic [4*DIGITS:0] bcd_value;
    logic              overflow;

    exp_t        sb[$];
    int          cyc;
    int          free_cycle;
    int          tests;
    int          fails;
    bit          checking;
    logic [24:0] last_val;
    logic        last_ovf;

    binary_to_bcd_encoder #(
        .BIN_W (BIN_W),
        .DIGITS(DIGITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .binary_in(binary_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_value(bcd_value),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digit extraction, saturating above 999999.
    function automatic logic [24:0] model_bcd(input int unsigned v);
        logic [24:0] r;
        int unsigned x;
        r = '0;
        x = v;
        if (v > 999999) return 25'h0999999;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [24:0] act,
                         input logic [24:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        exp_t e;
        if (checking) begin
            exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
            exp_busy = (sb.size() > 0) && (cyc > sb[0].start_cyc)
                       && (cyc <= sb[0].done_cyc);
            check("done", 25'(done), 25'(exp_done));
            check("busy", 25'(busy), 25'(exp_busy));
            if (exp_done) begin
                e = sb.pop_front();
                last_val = e.val;
                last_ovf = e.ovf;
            end
            check("bcd_value", bcd_value, last_val);
            check("overflow", 25'(overflow), 25'(last_ovf));
        end
    end

    // Drive one cycle of start; the model decides whether the DUT accepts it.
    task automatic issue(input logic [BIN_W-1:0] v);
        exp_t e;
        binary_in = v;
        start = 1'b1;
        if (cyc >= free_cycle) begin
            e.val       = model_bcd(32'(v));
            e.ovf       = (32'(v) > 999999);
            e.start_cyc = cyc;
            e.done_cyc  = cyc + LAT;
            sb.push_back(e);
            free_cycle  = cyc + LAT + 1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_free();
        int guard;
        guard = 0;
        while (cyc < free_cycle && guard < 100) begin
            idle(1);
            guard++;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        cyc        = 0;
        free_cycle = 0;
        tests      = 0;
        fails      = 0;
        checking   = 1'b0;
        last_val   = '0;
        last_ovf   = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        binary_in  = '0;
        idle(3);
        rst_n = 1'b1;
        free_cycle = cyc;
        checking = 1'b1;
        idle(5);

        issue(20'd123456);
        drain();
        issue(20'd999999);
        drain();
        issue(20'd1000000);
        drain();
        issue(20'd1048575);
        drain();
        issue(20'd0);
        drain();

        // Starts while busy must be ignored.
        wait_free();
        issue(20'd42);
        idle(4);
        for (int i = 0; i < 16; i++) issue(20'd7);
        drain();

        // Reset in the middle of a conversion discards it.
        issue(20'd500);
        drain();
        wait_free();
        issue(20'd900);
        idle(9);
        rst_n = 1'b0;
        idle(1);
        sb.delete();
        rst_n = 1'b1;
        last_val = '0;
        last_ovf = 1'b0;
        free_cycle = cyc;
        check("post_reset_value", bcd_value, 25'h0);
        issue(20'd9);
        drain();

        // Start held high restarts back to back.
        wait_free();
        for (int i = 0; i < 3 * (LAT + 1); i++) issue(20'd314159);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [BIN_W-1:0] v;
            if ($urandom_range(0, 3) == 0) v = BIN_W'($urandom_range(0, 1048575));
            else v = BIN_W'($urandom_range(0, 999999));
            wait_free();
            idle($urandom_range(0, 2));
            issue(v);
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 15));
                issue(BIN_W'($urandom));
            end
        end
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
